// File: rtl/mult_pipe_unit.sv
// Pipelined RV32M-style multiplier for the EX stage: configurable width and depth,
// with stall, trap flush, in-flight destination flags and a single writeback port.
`timescale 1ns/1ps
module mult_pipe_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            use_i,
    input  logic [1:0]      mult_type_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_we_o,
    output logic [4:0]      rd_addr_o,
    output logic [31:0]     rd_addr_flags_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        MUL_LO   = 2'b00,
        MUL_HSS  = 2'b01,
        MUL_HSU  = 2'b10,
        MUL_HUU  = 2'b11
    } mult_type_t;

    logic                  accept;
    logic                  a_signed;
    logic                  b_signed;
    logic [2*XLEN-1:0]     a_wide;
    logic [2*XLEN-1:0]     b_wide;
    logic [2*XLEN-1:0]     prod_next;

    logic                  valid  [1:STAGES];
    logic [4:0]            rd_q   [1:STAGES];
    logic [1:0]            type_q [1:STAGES];
    logic [2*XLEN-1:0]     prod_q [1:STAGES];

    assign accept = use_i & ~stall_i & ~flush_i;

    // Extending straight to 2*XLEN is equivalent to the XLEN+1 signed product, truncated.
    always_comb begin
        a_signed  = (mult_type_i != MUL_HUU);
        b_signed  = (mult_type_i == MUL_LO) || (mult_type_i == MUL_HSS);
        a_wide    = {{XLEN{a_signed & a_i[XLEN-1]}}, a_i};
        b_wide    = {{XLEN{b_signed & b_i[XLEN-1]}}, b_i};
        prod_next = a_wide * b_wide;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                valid[k]  <= 1'b0;
                rd_q[k]   <= '0;
                type_q[k] <= '0;
                prod_q[k] <= '0;
            end
        end else if (flush_i) begin
            for (int k = 1; k <= STAGES; k++) begin
                valid[k] <= 1'b0;
            end
        end else if (!stall_i) begin
            valid[1]  <= accept;
            rd_q[1]   <= rd_addr_i;
            type_q[1] <= mult_type_i;
            prod_q[1] <= prod_next;
            for (int k = STAGES; k >= 2; k--) begin
                valid[k]  <= valid[k-1];
                rd_q[k]   <= rd_q[k-1];
                type_q[k] <= type_q[k-1];
                prod_q[k] <= prod_q[k-1];
            end
        end
    end

    // Outputs are gated by rst so they read zero for the whole reset cycle.
    always_comb begin
        rd_we_o   = ~rst & valid[STAGES] & (rd_q[STAGES] != 5'd0) & ~stall_i & ~flush_i;
        rd_addr_o = '0;
        rd_data_o = '0;
        if (!rst && valid[STAGES]) begin
            rd_addr_o = rd_q[STAGES];
            rd_data_o = (type_q[STAGES] == MUL_LO) ? prod_q[STAGES][XLEN-1:0]
                                                   : prod_q[STAGES][2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        busy_o          = 1'b0;
        rd_addr_flags_o = '0;
        for (int k = 1; k <= STAGES; k++) begin
            busy_o = busy_o | valid[k];
            if (valid[k]) begin
                rd_addr_flags_o[rd_q[k]] = 1'b1;
            end
        end
        if (use_i && !flush_i) begin
            rd_addr_flags_o[rd_addr_i] = 1'b1;
        end
        rd_addr_flags_o[0] = 1'b0;
        if (rst || flush_i) begin
            rd_addr_flags_o = '0;
        end
        if (rst) begin
            busy_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_pipe_unit.sv
// Self-checking bench for mult_pipe_unit: vector table plus hand-written
// stall/flush/reset/x0 sequences, writebacks checked against a scoreboard.
`timescale 1ns/1ps
module tb_mult_pipe_unit;

    localparam int XLEN   = 32;
    localparam int STAGES = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            use_i;
    logic [1:0]      mult_type_i;
    logic [4:0]      rd_addr_i;
    logic            stall_i;
    logic            flush_i;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_we_o;
    logic [4:0]      rd_addr_o;
    logic [31:0]     rd_addr_flags_o;
    logic            busy_o;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mtype;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb [$];
    sb_t  head;
    int   cyc = 0;
    int   check_count = 0;
    int   pass_count = 0;

    mult_pipe_unit #(.XLEN(XLEN), .STAGES(STAGES)) dut (
        .clk             (clk),
        .rst             (rst),
        .a_i             (a_i),
        .b_i             (b_i),
        .use_i           (use_i),
        .mult_type_i     (mult_type_i),
        .rd_addr_i       (rd_addr_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .rd_data_o       (rd_data_o),
        .rd_we_o         (rd_we_o),
        .rd_addr_o       (rd_addr_o),
        .rd_addr_flags_o (rd_addr_flags_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        else
            pass_count++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                                 input logic [4:0] rd, input logic u, input logic s, input logic f);
        a_i         = a;
        b_i         = b;
        mult_type_i = t;
        rd_addr_i   = rd;
        use_i       = u;
        stall_i     = s;
        flush_i     = f;
    endtask

    task automatic idle();
        applyStimulus(32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Present an operation now; expect its writeback STAGES (+extra stall) cycles later.
    task automatic issueOp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                           input logic [4:0] rd, input logic [31:0] exp, input int extra);
        sb_t e;
        applyStimulus(a, b, t, rd, 1'b1, 1'b0, 1'b0);
        if (rd != 5'd0) begin
            e.rd   = rd;
            e.data = exp;
            e.cyc  = cyc + STAGES + extra;
            sb.push_back(e);
        end
    endtask

    // Every writeback must match the oldest scoreboard entry in data, address and cycle.
    always @(negedge clk) begin
        if (rd_we_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_wb", {59'd0, rd_addr_o}, 64'd0);
            end else begin
                head = sb.pop_front();
                checkOutput("wb_data", {32'd0, rd_data_o}, {32'd0, head.data});
                checkOutput("wb_addr", {59'd0, rd_addr_o}, {59'd0, head.rd});
                checkOutput("wb_cycle", 64'(cyc), 64'(head.cyc));
            end
        end
    end

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000002, 2'b00, 5'd5,  32'hFFFFFFFE};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000002, 2'b01, 5'd5,  32'hFFFFFFFF};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000002, 2'b10, 5'd5,  32'hFFFFFFFF};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000002, 2'b11, 5'd5,  32'h00000001};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 5'd5,  32'hFFFFFFFE};
        vecs[5] = '{32'h80000000, 32'h80000000, 2'b01, 5'd31, 32'h40000000};
        vecs[6] = '{32'h80000000, 32'h80000000, 2'b10, 5'd17, 32'hC0000000};
        vecs[7] = '{32'h80000000, 32'h80000000, 2'b11, 5'd9,  32'h40000000};

        rst = 1'b1;
        idle();
        tick();
        tick();
        applyStimulus(32'h3, 32'h3, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_we",    {63'd0, rd_we_o}, 64'd0);
        checkOutput("reset_busy",  {63'd0, busy_o}, 64'd0);
        checkOutput("reset_flags", {32'd0, rd_addr_flags_o}, 64'd0);
        checkOutput("reset_data",  {32'd0, rd_data_o}, 64'd0);
        checkOutput("reset_addr",  {59'd0, rd_addr_o}, 64'd0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        for (int i = 0; i < 8; i++) begin
            issueOp(vecs[i].a, vecs[i].b, vecs[i].mtype, vecs[i].rd, vecs[i].exp, 0);
            tick();
            idle();
            repeat (3) tick();
        end

        issueOp(32'd1, 32'd10, 2'b00, 5'd1, 32'd10, 0);
        tick();
        issueOp(32'd2, 32'd10, 2'b00, 5'd2, 32'd20, 0);
        tick();
        issueOp(32'd3, 32'd10, 2'b00, 5'd3, 32'd30, 0);
        @(negedge clk);
        checkOutput("b2b_flags", {32'd0, rd_addr_flags_o}, 64'h0000000E);
        checkOutput("b2b_busy",  {63'd0, busy_o}, 64'd1);
        tick();
        idle();
        @(negedge clk);
        checkOutput("b2b_flags_full", {32'd0, rd_addr_flags_o}, 64'h0000000E);
        repeat (4) tick();
        @(negedge clk);
        checkOutput("b2b_flags_done", {32'd0, rd_addr_flags_o}, 64'd0);
        checkOutput("b2b_busy_done",  {63'd0, busy_o}, 64'd0);

        issueOp(32'd7, 32'd6, 2'b00, 5'd6, 32'd42, 2);
        tick();
        idle();
        tick();
        applyStimulus(32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("stall_busy",  {63'd0, busy_o}, 64'd1);
        checkOutput("stall_flags", {32'd0, rd_addr_flags_o}, 64'h00000040);
        tick();
        tick();
        idle();
        repeat (3) tick();

        applyStimulus(32'd3, 32'd3, 2'b00, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(32'd4, 32'd4, 2'b00, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(32'd5, 32'd5, 2'b00, 5'd12, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_flags", {32'd0, rd_addr_flags_o}, 64'd0);
        checkOutput("flush_we",    {63'd0, rd_we_o}, 64'd0);
        tick();
        idle();
        @(negedge clk);
        checkOutput("flush_busy_after",  {63'd0, busy_o}, 64'd0);
        checkOutput("flush_flags_after", {32'd0, rd_addr_flags_o}, 64'd0);
        repeat (4) tick();

        applyStimulus(32'd6, 32'd6, 2'b00, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        applyStimulus(32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_last_we",   {63'd0, rd_we_o}, 64'd0);
        checkOutput("flush_last_busy", {63'd0, busy_o}, 64'd1);
        tick();
        idle();
        @(negedge clk);
        checkOutput("flush_last_busy_after", {63'd0, busy_o}, 64'd0);
        repeat (4) tick();

        issueOp(32'd3, 32'd4, 2'b00, 5'd0, 32'd12, 0);
        @(negedge clk);
        checkOutput("x0_flags_presented", {32'd0, rd_addr_flags_o}, 64'd0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("x0_busy",  {63'd0, busy_o}, 64'd1);
            checkOutput("x0_flags", {32'd0, rd_addr_flags_o}, 64'd0);
            tick();
        end
        @(negedge clk);
        checkOutput("x0_busy_done", {63'd0, busy_o}, 64'd0);

        applyStimulus(32'd2, 32'd3, 2'b00, 5'd20, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(32'd2, 32'd4, 2'b00, 5'd21, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_we",    {63'd0, rd_we_o}, 64'd0);
        checkOutput("midrst_busy",  {63'd0, busy_o}, 64'd0);
        checkOutput("midrst_flags", {32'd0, rd_addr_flags_o}, 64'd0);
        checkOutput("midrst_data",  {32'd0, rd_data_o}, 64'd0);
        checkOutput("midrst_addr",  {59'd0, rd_addr_o}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_busy",  {63'd0, busy_o}, 64'd0);
        checkOutput("postrst_flags", {32'd0, rd_addr_flags_o}, 64'd0);
        tick();
        issueOp(32'd5, 32'd5, 2'b00, 5'd22, 32'd25, 0);
        tick();
        idle();
        repeat (6) tick();

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mult_pipe_unit.md
# mult_pipe_unit

Parametrised pipelined multiply unit for the EX stage. It generalises the fixed 32-bit, fixed-depth multiplier manager with configurable operand width and pipeline depth, plus pipeline stall, trap flush, a busy indication, and an internal behavioural multiplier in place of an external IP core. It accepts RV32M-style MUL/MULH/MULHSU/MULHU operations from ID/EX, tracks in-flight destinations for the hazard unit, and drives one writeback port.

## Interface
- XLEN, 32: operand and result width.
- STAGES, 3: pipeline depth and issue-to-writeback latency; legal values are 1 or more.
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- a_i  input  XLEN  rs1 operand, taken from ID/EX.
- b_i  input  XLEN  rs2 operand, taken from ID/EX.
- use_i  input  1  a multiply operation is presented this cycle.
- mult_type_i  input  2  00 low XLEN bits; 01 SxS high; 10 SxU high (a signed, b unsigned); 11 UxU high.
- rd_addr_i  input  5  destination register.
- stall_i  input  1  freeze the whole pipeline.
- flush_i  input  1  trap flush; kills every in-flight and presented operation.
- rd_data_o  output  XLEN  writeback data.
- rd_we_o  output  1  writeback enable.
- rd_addr_o  output  5  writeback register.
- rd_addr_flags_o  output  32  bit r is set when register r has a pending multiply write.
- busy_o  output  1  at least one stage holds a valid entry.

## Operation
- Accept condition: use_i & ~stall_i & ~flush_i. Only an accepted operation enters stage 1.
- Operand extension to XLEN+1 bits:
  - a is sign-extended for types 00, 01 and 10, and zero-extended for type 11.
  - b is sign-extended for types 00 and 01, and zero-extended for types 10 and 11.
- The signed (XLEN+1)x(XLEN+1) product is computed from the accepted operands and registered into stage 1. Only bits [2*XLEN-1:0] are kept.
- Each stage k holds: valid, rd, type, and the product. The product moves from stage k to stage k+1 on every edge where stall_i is 0.
- Result selection at stage STAGES:
  - type 00 gives product[XLEN-1:0].
  - any other type gives product[2*XLEN-1:XLEN].
- Destination x0:
  - an entry with rd=0 travels through the pipe and counts toward busy_o.
  - rd_we_o stays 0 for it, and it never sets flag bit 0.
- rd_we_o = valid[STAGES] & (rd[STAGES]!=0) & ~stall_i & ~flush_i. When stall_i is 1, the last-stage entry is held and written exactly once, in the first cycle after the stall releases.
- rd_addr_o and rd_data_o come from stage STAGES. They are 0 whenever valid[STAGES] is 0.
- rd_addr_flags_o is combinational:
  - the OR over stages 1..STAGES of valid[k] for rd[k];
  - OR the presented operation, when use_i & ~flush_i, for rd_addr_i. The presented operation counts even while stalled.
  - Bit 0 is forced to 0. All bits are 0 while rst is 1 or flush_i is 1.
- busy_o = OR of valid[1..STAGES].
- Flush:
  - on the flush edge, every valid[k] is cleared;
  - in the flush cycle, rd_we_o is 0 combinationally;
  - flush takes priority over stall.

## Timing
- Reset: on the edge where rst is 1, every valid, rd, type and product register is cleared. All outputs are 0 from the following cycle, and while rst is 1. Reset mid-operation discards all in-flight entries with no writeback.
- Latency: an operation accepted at edge T reaches stage 1 after edge T. With no stalls, it is at stage STAGES and asserts rd_we_o in the cycle after edge T+STAGES-1, i.e. STAGES cycles after it was presented.
- Each cycle of stall_i adds exactly one cycle of latency to every in-flight entry.
- Throughput is one operation per unstalled cycle. Back-to-back operations write back on consecutive cycles, in issue order.
- When STAGES=1, stage 1 is also the output stage.
- No ready/accept handshake is exported. The upstream stall controller must not depend on this unit to hold operations.

## Test plan
- Types, with a=0xFFFFFFFF, b=0x00000002, rd=5, STAGES=3:
  - type 00 -> 0xFFFFFFFE;
  - type 01 -> 0xFFFFFFFF;
  - type 10 -> 0xFFFFFFFF;
  - type 11 -> 0x00000001.
  - Each writes rd_we_o=1 and rd_addr_o=5 exactly 3 cycles after issue.
  - Also type 11 with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- Back-to-back issue of rd=1, 2, 3 on consecutive cycles:
  - rd_addr_flags_o reaches 0x0000000E;
  - writebacks occur on 3 consecutive cycles in order 1, 2, 3;
  - flags and busy_o return to 0 after the last write.
- Stall for 2 cycles while one entry is at stage 2 -> writeback after 5 cycles, rd_we_o high for exactly one cycle, and the data is unchanged.
- flush_i with two entries in flight and use_i=1 -> no writeback ever occurs; flags are 0 in the flush cycle; busy_o=0 next cycle.
- rd=0 with a=3, b=4 -> busy_o=1 for 3 cycles, rd_we_o stays 0, flag bit 0 stays 0.
- Reset asserted for one cycle while 2 entries are in flight -> no writeback, all outputs 0; a new operation issued after reset completes with normal latency.
